// File: rtl/reg_writeback.sv
// reg_writeback -- write-back stage of the RV32E core.
//
// The only writer of the register-file write port. Results arrive from the
// EXU (ALU/CSR) and from the LSU (loads) over valid/ready handshakes. An
// arbiter accepts at most one of them per cycle. Load data is aligned and
// extended, and the chosen result is registered. It drives exactly one
// register write, or one retire, in the next cycle.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   wb_stall            when 1, accept nothing this cycle
//   exu_*               EXU result handshake: valid/ready, wen, rd, data
//   lsu_*               LSU load handshake: valid/ready, rd, raw word,
//                       addr_lo, size, unsigned
//   wen_reg, rd, rin    register-file write port
//   retire_valid        1-cycle pulse for each retired instruction
//   err_misalign        1-cycle pulse when a misaligned load is dropped
//   retire_cnt          retired-instruction counter; wraps around

// Load alignment and extension. The memory word is shifted down so the
// addressed byte sits at bit 0. The result is then cut to the access size
// and sign- or zero-extended.
module reg_wb_load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] data,
  output logic            misalign
);
  logic [XLEN-1:0] shifted;
  logic            sgn_b, sgn_h;

  always_comb begin
    shifted = raw >> {addr_lo, 3'b000};
    sgn_b   = ~uns & shifted[7];
    sgn_h   = ~uns & shifted[15];
    case (size)
      2'd0:    data = {{(XLEN-8){sgn_b}},  shifted[7:0]};
      2'd1:    data = {{(XLEN-16){sgn_h}}, shifted[15:0]};
      default: data = shifted;                    // size 3 behaves as a word
    endcase
    // size[1] covers both word encodings (2 and 3)
    misalign = ((size == 2'd1) && addr_lo[0]) || (size[1] && (addr_lo != 2'd0));
  end
endmodule

module reg_writeback #(
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_stall,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic             exu_wen,
  input  logic [4:0]       exu_rd,
  input  logic [XLEN-1:0]  exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic [1:0]       lsu_addr_lo,
  input  logic [1:0]       lsu_size,
  input  logic             lsu_unsigned,
  output logic             wen_reg,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  rin,
  output logic             retire_valid,
  output logic             err_misalign,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  // One write-back result, whichever source it comes from
  typedef struct packed {
    logic            wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            mis;
  } wb_res_t;

  logic [XLEN-1:0] ld_data;
  logic            ld_mis;

  reg_wb_load_align #(.XLEN(XLEN)) u_align (
    .raw      (lsu_data),
    .addr_lo  (lsu_addr_lo),
    .size     (lsu_size),
    .uns      (lsu_unsigned),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  logic [SW-1:0]    starve_q, starve_d;
  logic             wen_q, wen_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  rin_q, rin_d;
  logic             ret_q, ret_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic    can_grant, exu_force, exu_gnt, lsu_gnt, accept;
  wb_res_t res;

  always_comb begin
    // Grant is gated by reset so that nothing is handed over while the
    // stage is held in reset.
    can_grant = rst && !wb_stall;
    exu_force = (starve_q == LIM);
    // LSU wins ties unless the EXU has lost LIM times in a row. Each grant
    // looks at the other source's valid, never its own ready, so no loop.
    lsu_gnt   = can_grant && lsu_valid && !(exu_valid && exu_force);
    exu_gnt   = can_grant && exu_valid && (!lsu_valid || exu_force);
    accept    = exu_gnt || lsu_gnt;

    if (lsu_gnt) begin
      res.wen  = (lsu_rd != 5'd0) && !ld_mis;
      res.rd   = lsu_rd;
      res.data = ld_data;
      res.mis  = ld_mis;
    end else begin
      res.wen  = exu_wen && (exu_rd != 5'd0);
      res.rd   = exu_rd;
      res.data = exu_data;
      res.mis  = 1'b0;
    end

    // The starve count drops back to 0 whenever the EXU is idle or served
    if (!exu_valid || exu_gnt) starve_d = '0;
    else if (exu_force)        starve_d = starve_q;
    else                       starve_d = starve_q + SW'(1);

    // Write/retire strobes last one cycle. rd/rin keep their last value so
    // that a trace reads steadily between retires.
    wen_d = accept && res.wen;
    ret_d = accept;
    mis_d = accept && res.mis;
    rd_d  = accept ? res.rd   : rd_q;
    rin_d = accept ? res.data : rin_q;
    // The count moves on the same edge that raises retire_valid
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      wen_q    <= 1'b0;
      rd_q     <= 5'd0;
      rin_q    <= '0;
      ret_q    <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      starve_q <= starve_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      rin_q    <= rin_d;
      ret_q    <= ret_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign exu_ready    = exu_gnt;
  assign lsu_ready    = lsu_gnt;
  assign wen_reg      = wen_q;
  assign rd           = rd_q;
  assign rin          = rin_q;
  assign retire_valid = ret_q;
  assign err_misalign = mis_q;
  assign retire_cnt   = cnt_q;
endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
  logic        clk, rst, wb_stall;
  logic        exu_valid, exu_wen, lsu_valid, lsu_unsigned;
  logic [4:0]  exu_rd, lsu_rd;
  logic [31:0] exu_data, lsu_data;
  logic [1:0]  lsu_addr_lo, lsu_size;
  logic        exu_ready, lsu_ready, wen_reg, retire_valid, err_misalign;
  logic [4:0]  rd;
  logic [31:0] rin;
  logic [31:0] retire_cnt;
  // second instance with a 2-bit counter, for checking the wrap
  logic        w_er, w_lr, w_wen, w_ret, w_mis;
  logic [4:0]  w_rd;
  logic [31:0] w_rin;
  logic [1:0]  w_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  reg_writeback #(.XLEN(32), .STARVE_LIM(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_data(lsu_data), .lsu_addr_lo(lsu_addr_lo), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned),
    .wen_reg(wen_reg), .rd(rd), .rin(rin), .retire_valid(retire_valid),
    .err_misalign(err_misalign), .retire_cnt(retire_cnt)
  );

  reg_writeback #(.XLEN(32), .STARVE_LIM(4), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .exu_valid(exu_valid), .exu_ready(w_er), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(w_lr), .lsu_rd(lsu_rd),
    .lsu_data(lsu_data), .lsu_addr_lo(lsu_addr_lo), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned),
    .wen_reg(w_wen), .rd(w_rd), .rin(w_rin), .retire_valid(w_ret),
    .err_misalign(w_mis), .retire_cnt(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic ev; logic ew; logic [4:0] erd; logic [31:0] ed;
    logic lv; logic [4:0] lrd; logic [31:0] ld; logic [1:0] alo; logic [1:0] sz;
    logic uns; logic stall;
    logic x_er; logic x_lr; logic x_wen; logic x_ret; logic x_mis; logic chk;
    logic [4:0] x_rd; logic [31:0] x_rin;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ev, input logic ew, input logic [4:0] erd, input logic [31:0] ed,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic [1:0] alo, input logic [1:0] sz, input logic uns, input logic stall,
    input logic x_er, input logic x_lr, input logic x_wen, input logic x_ret,
    input logic x_mis, input logic chk, input logic [4:0] x_rd, input logic [31:0] x_rin);
    vec_t v;
    v.ev = ev; v.ew = ew; v.erd = erd; v.ed = ed;
    v.lv = lv; v.lrd = lrd; v.ld = ld; v.alo = alo; v.sz = sz;
    v.uns = uns; v.stall = stall;
    v.x_er = x_er; v.x_lr = x_lr; v.x_wen = x_wen; v.x_ret = x_ret;
    v.x_mis = x_mis; v.chk = chk; v.x_rd = x_rd; v.x_rin = x_rin;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0; lsu_addr_lo = 0; lsu_size = 0;
    lsu_unsigned = 0; wb_stall = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd3; exu_data = 32'h1;
    step(); step();
    // reset state, with a valid request that must not be granted
    chk("rst_exu_ready", exu_ready, 0);
    chk("rst_wen", wen_reg, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rin", rin, 0);
    chk("rst_ret", retire_valid, 0);
    chk("rst_mis", err_misalign, 0);
    chk("rst_cnt", retire_cnt, 0);
    idle_inputs();
    #2 rst = 1;
    step();

    //          ev ew erd    ed            lv lrd    ld            alo sz uns st  er lr wen ret mis chk rd     rin
    vecs.push_back(mk(1,1,5'd5, 32'h12345678, 0,5'd0, 32'h0,        0,0,0,0, 1,0,1,1,0,1, 5'd5, 32'h12345678));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd7, 32'h80FF7F01, 3,0,0,0, 0,1,1,1,0,1, 5'd7, 32'hFFFFFF80));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd7, 32'h80FF7F01, 3,0,1,0, 0,1,1,1,0,1, 5'd7, 32'h00000080));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd8, 32'h80011234, 2,1,0,0, 0,1,1,1,0,1, 5'd8, 32'hFFFF8001));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd12,32'h1234F00D, 0,1,1,0, 0,1,1,1,0,1, 5'd12,32'h0000F00D));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd31,32'hDEADBEEF, 0,2,0,0, 0,1,1,1,0,1, 5'd31,32'hDEADBEEF));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd13,32'h11223344, 1,0,1,0, 0,1,1,1,0,1, 5'd13,32'h00000033));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd9, 32'hCAFEBABE, 0,3,0,0, 0,1,1,1,0,1, 5'd9, 32'hCAFEBABE));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd10,32'h0000FFFF, 1,1,0,0, 0,1,0,1,1,0, 5'd10,32'h0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd11,32'h12345678, 2,2,0,0, 0,1,0,1,1,0, 5'd11,32'h0));
    vecs.push_back(mk(1,1,5'd0, 32'h00000055, 0,5'd0, 32'h0,        0,0,0,0, 1,0,0,1,0,1, 5'd0, 32'h00000055));
    vecs.push_back(mk(1,0,5'd3, 32'h00000077, 0,5'd0, 32'h0,        0,0,0,0, 1,0,0,1,0,1, 5'd3, 32'h00000077));
    vecs.push_back(mk(1,1,5'd6, 32'h00001111, 1,5'd6, 32'h00002222, 0,2,0,1, 0,0,0,0,0,0, 5'd0, 32'h0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd0, 32'h0000007F, 0,0,0,0, 0,1,0,1,0,1, 5'd0, 32'h0000007F));
    vecs.push_back(mk(1,1,5'd2, 32'hAAAA0000, 1,5'd14,32'h5555AAAA, 0,2,0,0, 0,1,1,1,0,1, 5'd14,32'h5555AAAA));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0, 32'h0,        0,0,0,0, 0,0,0,0,0,0, 5'd0, 32'h0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd15,32'h007F0000, 2,0,0,0, 0,1,1,1,0,1, 5'd15,32'h0000007F));

    foreach (vecs[i]) begin
      exu_valid = vecs[i].ev; exu_wen = vecs[i].ew; exu_rd = vecs[i].erd; exu_data = vecs[i].ed;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
      lsu_addr_lo = vecs[i].alo; lsu_size = vecs[i].sz; lsu_unsigned = vecs[i].uns;
      wb_stall = vecs[i].stall;
      #1;
      chk($sformatf("v%0d_exu_ready", i), exu_ready, vecs[i].x_er);
      chk($sformatf("v%0d_lsu_ready", i), lsu_ready, vecs[i].x_lr);
      step();
      exp_cnt += int'(vecs[i].x_ret);
      chk($sformatf("v%0d_wen", i), wen_reg, vecs[i].x_wen);
      chk($sformatf("v%0d_ret", i), retire_valid, vecs[i].x_ret);
      chk($sformatf("v%0d_mis", i), err_misalign, vecs[i].x_mis);
      chk($sformatf("v%0d_cnt", i), retire_cnt, exp_cnt);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_rd", i), rd, vecs[i].x_rd);
        chk($sformatf("v%0d_rin", i), rin, vecs[i].x_rin);
      end
    end

    // both sources valid for 6 cycles: LSU wins 4 times, then EXU once
    idle_inputs();
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd20; exu_data = 32'hE0E0E0E0;
    lsu_valid = 1; lsu_rd = 5'd21; lsu_data = 32'h1A1A1A1A; lsu_size = 2'd2;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("arb%0d_exu_ready", c), exu_ready, (c == 4));
      chk($sformatf("arb%0d_lsu_ready", c), lsu_ready, (c != 4));
      chk($sformatf("arb%0d_both_ready", c), exu_ready & lsu_ready, 0);
      step();
      exp_cnt++;
      chk($sformatf("arb%0d_ret", c), retire_valid, 1);
      chk($sformatf("arb%0d_rd", c), rd, (c == 4) ? 5'd20 : 5'd21);
      chk($sformatf("arb%0d_rin", c), rin, (c == 4) ? 32'hE0E0E0E0 : 32'h1A1A1A1A);
      chk($sformatf("arb%0d_cnt", c), retire_cnt, exp_cnt);
    end
    idle_inputs();
    step();
    chk("gap_ret", retire_valid, 0);
    chk("gap_wen", wen_reg, 0);

    // accept in flight, then asynchronous reset before the next edge
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd4; exu_data = 32'h0BADF00D;
    #1;
    chk("pre_rst_exu_ready", exu_ready, 1);
    #1 rst = 0;
    #1;
    chk("async_rst_cnt", retire_cnt, 0);
    chk("async_rst_ready", exu_ready, 0);
    step();
    chk("rst_hold_wen", wen_reg, 0);
    chk("rst_hold_ret", retire_valid, 0);
    chk("rst_hold_cnt", retire_cnt, 0);
    idle_inputs();
    #2 rst = 1;
    exp_cnt = 0;
    step();
    chk("post_rst_wen", wen_reg, 0);
    chk("post_rst_cnt", retire_cnt, 0);

    // back-to-back EXU retires; the 2-bit counter wraps on the 4th
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd1;
    for (int i = 0; i < 5; i++) begin
      exu_data = 32'h100 + i;
      step();
      exp_cnt++;
      chk($sformatf("wrap%0d_cnt", i), retire_cnt, exp_cnt);
      chk($sformatf("wrap%0d_cnt2", i), w_cnt, (i + 1) % 4);
      chk($sformatf("wrap%0d_rin", i), rin, 32'h100 + i);
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
